mem_access: RTL

//  Memory stage directly downstream of execute. Consumes result (ALU value or effective address),
//  rd_enablen and mem_enablen, plus the rs2 store data. Performs loads/stores on a req/ack data-memory

---
 rtl/mem_access_pkg.sv | 28 ++
 rtl/mem_access_load_align.sv | 25 ++
 rtl/mem_access.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory stage: RV32I opcodes, load/store width codes,
// the stage FSM states and a lane-mask helper.
package mem_access_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_e;

  // Active-high lane-0 mask for an access width; undefined codes act as a word.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   lane_mask = 4'b0001;
      2'b01:   lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Combinational load aligner: shifts the addressed lane down to bit 0 and
// sign- or zero-extends according to the load width.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_val
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_val = {24'h0, shifted[7:0]};
      F3_HU:   load_val = {16'h0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage: issues aligned loads/stores on a req/ack port, handles misalignment
// and timeouts, and emits one registered writeback beat per accepted op.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_addr,
  input  logic        rd_enablen,
  input  logic [3:0]  mem_enablen,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_benablen,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_rd_enablen,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        bus_err
);

  localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                req_q, req_d, we_q, we_d;
  logic [31:0]         addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]          ben_q, ben_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          f3_q, f3_d;
  logic                pend_rd_en_q, pend_rd_en_d;
  logic                wb_valid_q, wb_valid_d, wb_rd_en_q, wb_rd_en_d;
  logic [4:0]          wb_rd_addr_q, wb_rd_addr_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic                misalign_q, misalign_d, bus_err_q, bus_err_d;

  logic                is_load, is_store, bad_align;
  logic [3:0]          lane_en;
  logic [31:0]         load_val;

  load_align u_load_align (
    .rdata    (dmem_rdata),
    .offset   (off_q),
    .funct3   (f3_q),
    .load_val (load_val)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    timer_d      = timer_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ben_d        = ben_q;
    off_d        = off_q;
    f3_d         = f3_q;
    pend_rd_en_d = pend_rd_en_q;
    wb_valid_d   = 1'b0;
    wb_rd_en_d   = wb_rd_en_q;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_data_d    = wb_data_q;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;

    is_load   = (opcode == OPC_LOAD);
    is_store  = (opcode == OPC_STORE);
    bad_align = ((funct3[1:0] == 2'b01) && result[0]) ||
                ((funct3[1:0] != 2'b00) && (funct3[1:0] != 2'b01) && (result[1:0] != 2'b00));
    lane_en   = (is_load ? lane_mask(funct3) : ~mem_enablen) << result[1:0];

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          wb_rd_addr_d = rd_addr;
          pend_rd_en_d = rd_enablen | (rd_addr == 5'd0);
          if (!is_load && !is_store) begin
            wb_valid_d = 1'b1;
            wb_data_d  = result;
            wb_rd_en_d = rd_enablen | (rd_addr == 5'd0);
          end else if (bad_align || (is_store && mem_enablen == 4'b1111)) begin
            wb_valid_d = 1'b1;
            misalign_d = bad_align;
            wb_data_d  = 32'h0;
            wb_rd_en_d = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            timer_d = '0;
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {result[31:2], 2'b00};
            ben_d   = ~lane_en;
            wdata_d = store_data << {result[1:0], 3'b000};
            off_d   = result[1:0];
            f3_d    = funct3;
          end
        end
      end
      ST_ACCESS: begin
        if (dmem_ack) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = we_q ? 32'h0 : load_val;
          wb_rd_en_d = we_q ? 1'b1 : pend_rd_en_q;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          bus_err_d  = 1'b1;
          wb_data_d  = 32'h0;
          wb_rd_en_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      ben_q        <= 4'b1111;
      off_q        <= 2'b00;
      f3_q         <= 3'b000;
      pend_rd_en_q <= 1'b1;
      wb_valid_q   <= 1'b0;
      wb_rd_en_q   <= 1'b1;
      wb_rd_addr_q <= 5'd0;
      wb_data_q    <= 32'h0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ben_q        <= ben_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
      pend_rd_en_q <= pend_rd_en_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_en_q   <= wb_rd_en_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_data_q    <= wb_data_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE) & ~rst;
  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_benablen = ben_q;
  assign dmem_wdata    = wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd_enablen = wb_rd_en_q;
  assign wb_rd_addr    = wb_rd_addr_q;
  assign wb_data       = wb_data_q;
  assign misalign      = misalign_q;
  assign bus_err       = bus_err_q;

endmodule
